// File: rtl/ube_req_sequencer.sv
// UBE bus-request sequencer: snapshots the CSR1 request enables on GO and issues
// one request per enabled level by priority, each with an ack handshake and timeout.
module ube_req_sequencer #(
  parameter int unsigned TOCNT = 1023,
  parameter int unsigned TOW   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       csrGO,
  input  logic [3:0] csrBR,
  input  logic       csrNPRS,
  input  logic       devINTA,
  input  logic       devACKI,
  output logic [3:0] devINTR,
  output logic       devREQO,
  output logic       busy,
  output logic       done,
  output logic       toERR,
  output logic [4:0] pend
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARB  = 3'd1;
  localparam logic [2:0] INTR = 3'd2;
  localparam logic [2:0] NPR  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [TOW-1:0] TOLIM = TOW'(TOCNT);

  logic [2:0]     state;
  logic [TOW-1:0] counter;
  logic           toHit;
  logic [3:0]     brPick;

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign toHit = (counter == TOLIM);

  // Highest pending BR level as a one-hot devINTR pattern; zero when no BR is left.
  always_comb begin
    brPick = '0;
    if (pend[3])      brPick = 4'b1000;
    else if (pend[2]) brPick = 4'b0100;
    else if (pend[1]) brPick = 4'b0010;
    else if (pend[0]) brPick = 4'b0001;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= IDLE;
      devINTR <= '0;
      devREQO <= 1'b0;
      toERR   <= 1'b0;
      pend    <= '0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (csrGO) begin
            pend  <= {csrNPRS, csrBR};
            toERR <= 1'b0;
            state <= ARB;
          end
        end

        ARB: begin
          counter <= '0;
          if (brPick != 4'b0000) begin
            devINTR <= brPick;
            state   <= INTR;
          end else if (pend[4]) begin
            devREQO <= 1'b1;
            state   <= NPR;
          end else begin
            state <= DONE;
          end
        end

        INTR: begin
          // An ack arriving in the timeout cycle still counts as a normal completion.
          if (devINTA || toHit) begin
            devINTR   <= '0;
            pend[3:0] <= pend[3:0] & ~devINTR;
            if (!devINTA) toERR <= 1'b1;
            state     <= ARB;
          end else if (counter != '1) begin
            counter <= counter + 1'b1;
          end
        end

        NPR: begin
          if (devACKI || toHit) begin
            devREQO <= 1'b0;
            pend[4] <= 1'b0;
            if (!devACKI) toERR <= 1'b1;
            state   <= ARB;
          end else if (counter != '1) begin
            counter <= counter + 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
